// File: rtl/brus16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : brus16_pkg
//  Description : Shared types and constants for the frame scheduler and GPU.
//                Holds the scheduler state encoding, the default copy window
//                (also used by the GPU register file) and an 8-bit
//                saturating increment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package brus16_pkg;

    // Scheduler states; 3 bits hold all five states.
    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_WAIT_VSYNC = 3'd1,
        ST_COPY       = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_RESUME     = 3'd4
    } sched_state_e;

    // Default copy window, shared with the GPU register file sizing.
    localparam logic [12:0] DEF_COPY_BASE = 13'h0000;
    localparam int          DEF_COPY_LEN  = 384;
    localparam int          DEF_GPU_AW    = 9;

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

endpackage : brus16_pkg
`default_nettype wire

// File: rtl/frame_sched.sv
`default_nettype none
// ============================================================================
//  Module      : frame_sched
//  Description : Per-frame scheduler. When the CPU halts at end of frame and
//                vsync arrives, it borrows the data bsram read port, copies
//                COPY_LEN words starting at COPY_BASE into the GPU register
//                file and then pulses the CPU resume input.
//  Ports       : clk, reset (async, active-low)
//                vsync, cpu_halted          -> frame handshake inputs
//                cpu_resume                 -> one-cycle CPU resume pulse
//                cpu_mem_din_addr/dout_we   -> CPU side of the bsram port
//                mem_din_addr, mem_we       -> muxed/gated bsram controls
//                mem_dout                   -> bsram read data (1-cycle latency)
//                gpu_we, gpu_addr, gpu_data -> GPU register file write port
//                busy                       -> copy in progress
//                overrun_cnt                -> saturating dropped-frame count
//  Revision    : 1.0  initial release
// ============================================================================
module frame_sched
    import brus16_pkg::*;
#(
    parameter int                    DATA_WIDTH = 13,
    parameter logic [DATA_WIDTH-1:0] COPY_BASE  = DATA_WIDTH'(DEF_COPY_BASE),
    parameter int                    COPY_LEN   = DEF_COPY_LEN,
    parameter int                    GPU_AW     = DEF_GPU_AW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  cpu_halted,
    output logic                  cpu_resume,
    input  logic [DATA_WIDTH-1:0] cpu_mem_din_addr,
    input  logic                  cpu_mem_dout_we,
    output logic [DATA_WIDTH-1:0] mem_din_addr,
    output logic                  mem_we,
    input  logic [15:0]           mem_dout,
    output logic                  gpu_we,
    output logic [GPU_AW-1:0]     gpu_addr,
    output logic [15:0]           gpu_data,
    output logic                  busy,
    output logic [7:0]            overrun_cnt
);

    localparam logic [GPU_AW-1:0] LAST_INDEX = GPU_AW'(COPY_LEN - 1);

    sched_state_e      state_q, state_d;
    logic [GPU_AW-1:0] index_q, index_d;
    // Read issued last cycle: its data is on mem_dout now.
    logic              wr_pend_q, wr_pend_d;
    logic [GPU_AW-1:0] wr_addr_q, wr_addr_d;
    // Resume was asserted last cycle; blocks re-entry while halt drops.
    logic              resume_prev_q, resume_prev_d;
    logic [7:0]        overrun_q, overrun_d;

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        wr_pend_d     = 1'b0;
        wr_addr_d     = wr_addr_q;
        resume_prev_d = (state_q == ST_RESUME);
        overrun_d     = overrun_q;

        unique case (state_q)
            ST_RUN: begin
                // vsync while running means this frame missed its copy,
                // including the cycle in which the halt is first seen.
                if (vsync) begin
                    overrun_d = sat_inc8(overrun_q);
                end
                if (cpu_halted && !resume_prev_q) begin
                    state_d = ST_WAIT_VSYNC;
                end
            end
            ST_WAIT_VSYNC: begin
                // Halt dropping here is a protocol error: abandon quietly.
                if (!cpu_halted) begin
                    state_d = ST_RUN;
                end else if (vsync) begin
                    state_d = ST_COPY;
                    index_d = '0;
                end
            end
            ST_COPY: begin
                wr_pend_d = 1'b1;
                wr_addr_d = index_q;
                if (index_q == LAST_INDEX) begin
                    state_d = ST_DRAIN;
                end else begin
                    index_d = index_q + GPU_AW'(1);
                end
            end
            ST_DRAIN:  state_d = ST_RESUME;
            ST_RESUME: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            index_q       <= '0;
            wr_pend_q     <= 1'b0;
            wr_addr_q     <= '0;
            resume_prev_q <= 1'b0;
            overrun_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            wr_pend_q     <= wr_pend_d;
            wr_addr_q     <= wr_addr_d;
            resume_prev_q <= resume_prev_d;
            overrun_q     <= overrun_d;
        end
    end

    assign mem_din_addr = (state_q == ST_COPY)
                        ? COPY_BASE + DATA_WIDTH'(index_q)
                        : cpu_mem_din_addr;
    assign mem_we       = (state_q == ST_RUN) ? cpu_mem_dout_we : 1'b0;

    // The bsram output register is the write-data stage, so the GPU write
    // strobe comes straight from the pending flag without another register.
    assign gpu_we       = wr_pend_q;
    assign gpu_addr     = wr_addr_q;
    assign gpu_data     = wr_pend_q ? mem_dout : 16'd0;

    assign cpu_resume   = (state_q == ST_RESUME);
    assign busy         = (state_q == ST_COPY) || (state_q == ST_DRAIN);
    assign overrun_cnt  = overrun_q;

endmodule : frame_sched
`default_nettype wire
